// File: rtl/bitonic_pkg.sv
// Shared FSM states, pass count and per-pass lane permutation/direction tables
// for the 4-lane bitonic pass sequencer.
package bitonic_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int NUM_PASS = 3;

  // Each row lists, for datapath lanes 3..0, the frame lane that feeds it.
  localparam logic [7:0] PERM_IDENT   = {2'd3, 2'd2, 2'd1, 2'd0};
  localparam logic [7:0] PERM_MIDSWAP = {2'd3, 2'd1, 2'd2, 2'd0};
  localparam logic [7:0] PERM_TAB [NUM_PASS] = '{PERM_IDENT, PERM_MIDSWAP, PERM_IDENT};

  // Passes on which pair 1 runs opposite to the frame direction.
  localparam logic [NUM_PASS-1:0] DIR_HI_INV = 3'b001;

  function automatic logic [1:0] perm_src(input logic [1:0] pass, input logic [1:0] lane);
    logic [7:0] row;
    row = (pass < 2'(NUM_PASS)) ? PERM_TAB[pass] : PERM_IDENT;
    return row[{lane, 1'b0} +: 2];
  endfunction

  function automatic logic dir_hi_inv(input logic [1:0] pass);
    return (pass < 2'(NUM_PASS)) ? DIR_HI_INV[pass] : 1'b0;
  endfunction

endpackage

// File: rtl/bitonic_lane_perm.sv
// Combinational lane shuffle: perm_vec routes frame lanes onto datapath lanes for
// the given pass, unperm_vec applies the inverse mapping. Zero latency.
module bitonic_lane_perm
  import bitonic_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [1:0]     pass,
  input  logic [4*W-1:0] vec,
  output logic [4*W-1:0] perm_vec,
  output logic [4*W-1:0] unperm_vec
);

  always_comb begin
    int src;
    perm_vec   = '0;
    unperm_vec = '0;
    for (int j = 0; j < 4; j++) begin
      src = int'(perm_src(pass, 2'(j)));
      perm_vec[j*W +: W]     = vec[src*W +: W];
      unperm_vec[src*W +: W] = vec[j*W +: W];
    end
  end

endmodule

// File: rtl/bitonic_pass_sched.sv
// Drives one 4-word frame through the shared compare-exchange datapath three times;
// output after 3*(DP_LAT+1) cycles, held in DONE until out_ready, no input accepted meanwhile.
module bitonic_pass_sched
  import bitonic_pkg::*;
#(
  parameter int W      = 16,
  parameter int DP_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4*W-1:0] in_data,
  input  logic           in_dir,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*W-1:0] out_data,
  output logic           busy,
  output logic [1:0]     pass_idx,
  output logic [4*W-1:0] dp_in,
  output logic           dp_dir_lo,
  output logic           dp_dir_hi,
  input  logic [4*W-1:0] dp_out
);

  localparam logic [2:0] WAIT_INIT = (DP_LAT > 0) ? 3'(DP_LAT - 1) : 3'd0;

  state_t         state_q, state_d;
  logic [1:0]     pass_q, pass_d;
  logic [2:0]     wait_q, wait_d;
  logic [4*W-1:0] work_q, work_d;
  logic           dir_q, dir_d;
  logic           capture;
  logic           issuing;

  logic [4*W-1:0] perm_work, unperm_dp;
  logic [4*W-1:0] unused_fwd_unperm, unused_rev_perm;

  bitonic_lane_perm #(.W(W)) u_perm_work (
    .pass       (pass_q),
    .vec        (work_q),
    .perm_vec   (perm_work),
    .unperm_vec (unused_fwd_unperm)
  );

  bitonic_lane_perm #(.W(W)) u_unperm_dp (
    .pass       (pass_q),
    .vec        (dp_out),
    .perm_vec   (unused_rev_perm),
    .unperm_vec (unperm_dp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pass_q  <= 2'd0;
      wait_q  <= 3'd0;
      work_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      wait_q  <= wait_d;
      work_q  <= work_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    wait_d  = wait_q;
    work_d  = work_q;
    dir_d   = dir_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          dir_d   = in_dir;
          pass_d  = 2'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A zero-latency datapath answers in the same cycle it is driven.
        if (DP_LAT == 0) begin
          capture = 1'b1;
        end else begin
          wait_d  = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == 3'd0) capture = 1'b1;
        else                wait_d  = wait_q - 3'd1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      work_d = unperm_dp;
      if (pass_q < 2'(NUM_PASS - 1)) begin
        pass_d  = pass_q + 2'd1;
        state_d = ISSUE;
      end else begin
        state_d = DONE;
      end
    end
  end

  always_comb begin
    issuing   = (state_q == ISSUE) || (state_q == WAIT);
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    pass_idx  = busy ? pass_q : 2'd0;
    out_data  = out_valid ? work_q : '0;
    dp_in     = issuing ? perm_work : '0;
    dp_dir_lo = issuing & dir_q;
    dp_dir_hi = issuing & (dir_q ^ dir_hi_inv(pass_q));
  end

endmodule

// File: tb/tb_bitonic_pass_sched.sv
// Bench for bitonic_pass_sched: datapath models for DP_LAT 0/1/3 and a sort-based
// reference for the final frame order, latency and pass controls.
module tb_bitonic_pass_sched;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // DP_LAT = 1 instance
  logic           in_valid = 1'b0, in_dir = 1'b0, out_ready = 1'b0;
  logic           in_ready, out_valid, busy, dp_dir_lo, dp_dir_hi;
  logic [4*W-1:0] in_data = '0, out_data, dp_in, dp_out = '0;
  logic [1:0]     pass_idx;

  // DP_LAT = 0 instance
  logic           in_valid_l0 = 1'b0, in_dir_l0 = 1'b0, out_ready_l0 = 1'b0;
  logic           in_ready_l0, out_valid_l0, busy_l0, dp_dir_lo_l0, dp_dir_hi_l0;
  logic [4*W-1:0] in_data_l0 = '0, out_data_l0, dp_in_l0, dp_out_l0;
  logic [1:0]     pass_idx_l0;

  // DP_LAT = 3 instance
  logic           in_valid_l3 = 1'b0, in_dir_l3 = 1'b0, out_ready_l3 = 1'b0;
  logic           in_ready_l3, out_valid_l3, busy_l3, dp_dir_lo_l3, dp_dir_hi_l3;
  logic [4*W-1:0] in_data_l3 = '0, out_data_l3, dp_in_l3, dp_out_l3 = '0;
  logic [1:0]     pass_idx_l3;
  logic [4*W-1:0] dp3_s1 = '0, dp3_s2 = '0;

  bitonic_pass_sched #(.W(W), .DP_LAT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dir(in_dir), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .pass_idx(pass_idx), .dp_in(dp_in), .dp_dir_lo(dp_dir_lo),
    .dp_dir_hi(dp_dir_hi), .dp_out(dp_out)
  );

  bitonic_pass_sched #(.W(W), .DP_LAT(0)) dut_l0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_l0), .in_ready(in_ready_l0), .in_data(in_data_l0),
    .in_dir(in_dir_l0), .out_valid(out_valid_l0), .out_ready(out_ready_l0), .out_data(out_data_l0),
    .busy(busy_l0), .pass_idx(pass_idx_l0), .dp_in(dp_in_l0), .dp_dir_lo(dp_dir_lo_l0),
    .dp_dir_hi(dp_dir_hi_l0), .dp_out(dp_out_l0)
  );

  bitonic_pass_sched #(.W(W), .DP_LAT(3)) dut_l3 (
    .clk(clk), .rst(rst), .in_valid(in_valid_l3), .in_ready(in_ready_l3), .in_data(in_data_l3),
    .in_dir(in_dir_l3), .out_valid(out_valid_l3), .out_ready(out_ready_l3), .out_data(out_data_l3),
    .busy(busy_l3), .pass_idx(pass_idx_l3), .dp_in(dp_in_l3), .dp_dir_lo(dp_dir_lo_l3),
    .dp_dir_hi(dp_dir_hi_l3), .dp_out(dp_out_l3)
  );

  function automatic logic [63:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  // Two-pair compare-exchange: dir 0 puts the minimum in the lower lane.
  function automatic logic [63:0] cmpx(input logic [63:0] v, input logic dlo, input logic dhi);
    logic [63:0] r;
    r = v;
    if ((!dlo && v[31:16] < v[15:0]) || (dlo && v[31:16] > v[15:0])) begin
      r[15:0] = v[31:16]; r[31:16] = v[15:0];
    end
    if ((!dhi && v[63:48] < v[47:32]) || (dhi && v[63:48] > v[47:32])) begin
      r[47:32] = v[63:48]; r[63:48] = v[47:32];
    end
    return r;
  endfunction

  // Reference: fully sorted frame, ascending or descending toward lane 0.
  function automatic logic [63:0] ref_sort(input logic [63:0] v, input logic dir);
    logic [15:0] e [4];
    logic [15:0] t;
    logic [63:0] r;
    for (int i = 0; i < 4; i++) e[i] = v[i*16 +: 16];
    for (int i = 1; i < 4; i++)
      for (int j = i; j > 0; j--)
        if (e[j-1] > e[j]) begin t = e[j]; e[j] = e[j-1]; e[j-1] = t; end
    for (int k = 0; k < 4; k++) r[k*16 +: 16] = dir ? e[3-k] : e[k];
    return r;
  endfunction

  assign dp_out_l0 = cmpx(dp_in_l0, dp_dir_lo_l0, dp_dir_hi_l0);

  always @(posedge clk) begin
    dp_out    <= cmpx(dp_in, dp_dir_lo, dp_dir_hi);
    dp3_s1    <= cmpx(dp_in_l3, dp_dir_lo_l3, dp_dir_hi_l3);
    dp3_s2    <= dp3_s1;
    dp_out_l3 <= dp3_s2;
  end

  // Caller sits at a negedge; returns just after the handshake edge.
  task automatic send_frame(input logic [63:0] d, input logic dir);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    in_valid = 1'b1; in_data = d; in_dir = dir;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0;
  endtask

  // Counts edges after the handshake until out_valid is seen at a negedge.
  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic take_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, pass_idx, dp_dir_lo, dp_dir_hi} !== 7'b1000000 ||
        dp_in !== '0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_values: ready=%b valid=%b busy=%b pass=%0d dlo=%b dhi=%b dp_in=%h out=%h; required ready=1, all others 0",
               in_ready, out_valid, busy, pass_idx, dp_dir_lo, dp_dir_hi, dp_in, out_data);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b busy=%b valid=%b; required 1 0 0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_ascending;
    logic [63:0] d;
    int lat;
    d = pack4(16'd3, 16'd1, 16'd4, 16'd2);
    send_frame(d, 1'b0);
    wait_out(lat);
    n_checks++;
    if (lat != 6) begin n_fail++; $display("FAIL asc_latency: got %0d, required 6", lat); end
    n_checks++;
    if (out_data !== pack4(16'd1, 16'd2, 16'd3, 16'd4)) begin
      n_fail++; $display("FAIL asc_data: got %h, required %h", out_data, pack4(16'd1, 16'd2, 16'd3, 16'd4));
    end
    take_out();
  endtask

  task automatic test_descending_dirs;
    logic [63:0] d;
    logic [1:0]  exp_pass;
    logic        exp_hi;
    d = pack4(16'd3, 16'd1, 16'd4, 16'd2);
    send_frame(d, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_pass = 2'(k / 2);
      exp_hi   = (exp_pass == 2'd0) ? 1'b0 : 1'b1;
      n_checks++;
      if (pass_idx !== exp_pass || dp_dir_lo !== 1'b1 || dp_dir_hi !== exp_hi || busy !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL desc_pass_ctrl cyc%0d: pass=%0d dlo=%b dhi=%b busy=%b valid=%b; required pass=%0d dlo=1 dhi=%b busy=1 valid=0",
                 k, pass_idx, dp_dir_lo, dp_dir_hi, busy, out_valid, exp_pass, exp_hi);
      end
      if (k == 0) begin
        n_checks++;
        if (dp_in !== d) begin n_fail++; $display("FAIL desc_dp_in_pass0: got %h, required %h", dp_in, d); end
      end
      @(posedge clk);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== pack4(16'd4, 16'd3, 16'd2, 16'd1)) begin
      n_fail++; $display("FAIL desc_data: valid=%b data=%h, required 1 %h", out_valid, out_data, pack4(16'd4, 16'd3, 16'd2, 16'd1));
    end
    take_out();
  endtask

  task automatic test_extremes;
    int lat;
    send_frame(pack4(16'd5, 16'hFFFF, 16'd5, 16'd0), 1'b0);
    wait_out(lat);
    n_checks++;
    if (lat != 6 || out_data !== pack4(16'd0, 16'd5, 16'd5, 16'hFFFF)) begin
      n_fail++; $display("FAIL extremes: lat=%0d data=%h, required 6 %h", lat, out_data, pack4(16'd0, 16'd5, 16'd5, 16'hFFFF));
    end
    take_out();
  endtask

  task automatic test_backpressure;
    logic [63:0] d, d2, exp;
    int lat;
    d = {$urandom, $urandom};
    exp = ref_sort(d, 1'b0);
    send_frame(d, 1'b0);
    wait_out(lat);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom}; in_dir = 1'($urandom);
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d: valid=%b data=%h ready=%b, required 1 %h 0", k, out_valid, out_data, in_ready, exp);
      end
    end
    d2 = {$urandom, $urandom};
    in_data = d2; in_dir = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: ready=%b valid=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out(lat);
    n_checks++;
    if (lat != 6 || out_data !== ref_sort(d2, 1'b1)) begin
      n_fail++; $display("FAIL bp_next_frame: lat=%0d data=%h, required 6 %h", lat, out_data, ref_sort(d2, 1'b1));
    end
    take_out();
  endtask

  task automatic test_reset_mid;
    int lat;
    send_frame(pack4(16'd9, 16'd8, 16'd7, 16'd6), 1'b0);
    repeat (4) @(negedge clk);
    n_checks++;
    if (pass_idx !== 2'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_setup: pass=%0d busy=%b, required 1 1", pass_idx, busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, pass_idx, dp_dir_lo, dp_dir_hi} !== 7'b1000000 ||
        dp_in !== '0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL rstmid_values: ready=%b valid=%b busy=%b pass=%0d dlo=%b dhi=%b dp_in=%h out=%h; required ready=1, all others 0",
               in_ready, out_valid, busy, pass_idx, dp_dir_lo, dp_dir_hi, dp_in, out_data);
    end
    in_valid = 1'b1; in_data = pack4(16'd2, 16'd2, 16'd1, 16'd1); in_dir = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_held cyc%0d: valid=%b busy=%b, required 0 0", k, out_valid, busy);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out(lat);
    n_checks++;
    if (lat != 6 || out_data !== pack4(16'd1, 16'd1, 16'd2, 16'd2)) begin
      n_fail++; $display("FAIL rstmid_fresh: lat=%0d data=%h, required 6 %h", lat, out_data, pack4(16'd1, 16'd1, 16'd2, 16'd2));
    end
    take_out();
  endtask

  task automatic test_random;
    logic [63:0] d;
    logic        dir;
    int lat;
    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < 4; k++)
        d[k*16 +: 16] = (n % 2 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      dir = 1'($urandom);
      send_frame(d, dir);
      wait_out(lat);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); @(negedge clk); end
      n_checks++;
      if (lat != 6 || out_valid !== 1'b1 || out_data !== ref_sort(d, dir)) begin
        n_fail++;
        $display("FAIL random%0d: in=%h dir=%b lat=%0d valid=%b data=%h, required lat 6 %h",
                 n, d, dir, lat, out_valid, out_data, ref_sort(d, dir));
      end
      take_out();
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] f [4];
    logic        fd [4];
    int idx, oi, last_acc;
    bit acc;
    for (int i = 0; i < 4; i++) begin f[i] = {$urandom, $urandom}; fd[i] = 1'($urandom); end
    idx = 0; oi = 0; last_acc = -1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = f[0]; in_dir = fd[0];
    for (int c = 0; c < 40; c++) begin
      acc = 1'b0;
      if (out_valid && oi < 4) begin
        n_checks++;
        if (out_data !== ref_sort(f[oi], fd[oi])) begin
          n_fail++; $display("FAIL b2b_data%0d: got %h, required %h", oi, out_data, ref_sort(f[oi], fd[oi]));
        end
        oi++;
      end
      if (in_valid && in_ready) begin
        if (last_acc >= 0) begin
          n_checks++;
          if (c - last_acc != 8) begin
            n_fail++; $display("FAIL b2b_interval: got %0d cycles, required 8", c - last_acc);
          end
        end
        last_acc = c; acc = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 4) begin in_data = f[idx]; in_dir = fd[idx]; end
        else in_valid = 1'b0;
      end
      @(negedge clk);
    end
    out_ready = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (oi != 4) begin n_fail++; $display("FAIL b2b_count: got %0d frames out, required 4", oi); end
  endtask

  task automatic test_dp_lat;
    logic [63:0] d;
    logic        dir;
    int lat;
    for (int n = 0; n < 5; n++) begin
      d   = (n == 0) ? pack4(16'd3, 16'd1, 16'd4, 16'd2) : {$urandom, $urandom};
      dir = (n == 0) ? 1'b0 : 1'($urandom);
      in_valid_l0 = 1'b1; in_data_l0 = d; in_dir_l0 = dir;
      @(posedge clk); #1 in_valid_l0 = 1'b0;
      lat = 0;
      while (lat < 100) begin @(posedge clk); lat++; @(negedge clk); if (out_valid_l0) break; end
      n_checks++;
      if (lat != 3 || out_data_l0 !== ref_sort(d, dir)) begin
        n_fail++; $display("FAIL lat0_frame%0d: lat=%0d data=%h, required 3 %h", n, lat, out_data_l0, ref_sort(d, dir));
      end
      out_ready_l0 = 1'b1; @(posedge clk); #1 out_ready_l0 = 1'b0; @(negedge clk);

      in_valid_l3 = 1'b1; in_data_l3 = d; in_dir_l3 = dir;
      @(posedge clk); #1 in_valid_l3 = 1'b0;
      lat = 0;
      while (lat < 100) begin @(posedge clk); lat++; @(negedge clk); if (out_valid_l3) break; end
      n_checks++;
      if (lat != 12 || out_data_l3 !== ref_sort(d, dir) || busy_l3 !== 1'b1) begin
        n_fail++; $display("FAIL lat3_frame%0d: lat=%0d data=%h busy=%b, required 12 %h 1", n, lat, out_data_l3, busy_l3, ref_sort(d, dir));
      end
      out_ready_l3 = 1'b1; @(posedge clk); #1 out_ready_l3 = 1'b0; @(negedge clk);
    end
    n_checks++;
    if (busy_l0 !== 1'b0 || in_ready_l3 !== 1'b1) begin
      n_fail++; $display("FAIL lat_idle: busy_l0=%b ready_l3=%b, required 0 1", busy_l0, in_ready_l3);
    end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_descending_dirs();
    test_extremes();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_dp_lat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bitonic_pass_sched.md
# bitonic_pass_sched

Sequencer for the 4-lane bitonic compare-exchange datapath. It accepts one 4-word frame over a valid/ready handshake and drives it through the shared datapath three times, once per bitonic pass. For each pass it sets the lane permutation and per-pair directions, then returns the sorted frame over a second valid/ready handshake. It sits between the frame source and the sink, and owns the datapath's input and direction controls exclusively.

## Interface
- W, 16: element width in bits; elements are compared as unsigned values.
- DP_LAT, 1: datapath register latency in cycles, from dp_in to dp_out; legal range 0..7.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input frame valid.
- in_ready  out  1  block can accept a frame.
- in_data  in  4*W  lane k at [k*W +: W].
- in_dir  in  1  sort direction; 0 = ascending toward lane 0, 1 = descending.
- out_valid  out  1  sorted frame valid.
- out_ready  in  1  sink accepts the frame.
- out_data  out  4*W  sorted frame, same lane packing as in_data.
- busy  out  1  high in the ISSUE, WAIT and DONE states.
- pass_idx  out  2  current pass: 0, 1 or 2; 0 when idle.
- dp_in  out  4*W  datapath input; pair 0 = lanes 0/1, pair 1 = lanes 2/3.
- dp_dir_lo  out  1  direction for datapath pair 0.
- dp_dir_hi  out  1  direction for datapath pair 1.
- dp_out  in  4*W  datapath result, valid DP_LAT cycles after dp_in.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture in_data into work_q and in_dir into dir_q; set pass = 0; go to ISSUE.
- ISSUE:
  - Lasts one cycle and presents perm(work_q, pass) on dp_in.
  - If DP_LAT = 0: capture unperm(dp_out) into work_q in this cycle and advance, as described under "Advance".
  - Otherwise: load wait_cnt = DP_LAT-1 and go to WAIT.
- WAIT:
  - dp_in and the directions are held.
  - wait_cnt decrements each cycle.
  - When wait_cnt = 0: capture unperm(dp_out) into work_q and advance.
- Advance:
  - If pass < 2: increment pass and go to ISSUE.
  - Otherwise go to DONE.
- DONE:
  - out_valid = 1 and out_data = work_q, both held stable.
  - On out_ready: go to IDLE.
  - in_ready stays 0 in the cycle of the output handshake; there is no same-cycle turnaround.
- Pass schedule:
  - Pass 0: permutation is identity; dp_dir_lo = dir_q, dp_dir_hi = ~dir_q.
  - Pass 1: permutation maps lanes (0,2,1,3) onto datapath lanes (0,1,2,3); both directions = dir_q.
  - Pass 2: permutation is identity; both directions = dir_q.
- unperm is the exact inverse of perm for the current pass.
- Compare-exchange semantics of the datapath, per pair:
  - dir = 0: the lower lane receives the minimum.
  - dir = 1: the lower lane receives the maximum.
  - Equal values pass through unchanged.
- In IDLE, dp_in = 0 and both directions = 0.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1.
  - out_valid, busy, pass_idx, dp_in, dp_dir_lo, dp_dir_hi = 0.
  - out_data = 0, work_q = 0.
- Latency: out_valid rises 3*(DP_LAT+1) cycles after the input handshake edge. With DP_LAT = 1 this is 6 cycles.
- Throughput: one frame per 3*(DP_LAT+1) + 2 cycles when out_ready is held high.
- in_valid outside IDLE is ignored, and in_data is not sampled.
- out_ready outside DONE is ignored.
- Reset asserted in any state (mid-pass included):
  - All outputs return immediately to their reset values.
  - The frame in flight is discarded.
  - The first possible acceptance is on the first rising edge after rst deasserts.
- dp_out is sampled only on the capture cycle; its value in all other cycles is don't-care.

## Structure
- Shared package bitonic_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, DONE};
  - constant NUM_PASS = 3;
  - the per-pass permutation table and direction-select constants.
- One sub-module, bitonic_lane_perm: purely combinational. Inputs are pass and a 4*W vector; outputs are perm(vector) and unperm(vector).
- FSM, wait counter, pass counter and work_q live in bitonic_pass_sched.
- The testbench supplies the datapath model: a registered 2-pair compare-exchange with DP_LAT stages.

## Test plan
- Ascending sort, W=16, DP_LAT=1: lanes 0..3 = 3,1,4,2 with in_dir = 0. Required: out lanes = 1,2,3,4, with out_valid exactly 6 cycles after the handshake.
- Descending sort and pass directions: same frame with in_dir = 1. Required: out lanes = 4,3,2,1. During pass 0, dp_dir_lo = 1 and dp_dir_hi = 0; during passes 1 and 2, both directions = 1. pass_idx steps 0 → 1 → 2.
- Duplicates and extremes: lanes = 5, 0xFFFF, 5, 0 with in_dir = 0. Required: 0, 5, 5, 0xFFFF (unsigned ordering).
- Backpressure and ignored input: hold out_ready = 0 for 10 cycles after out_valid rises, and drive in_valid = 1 with new data throughout. Required: out_data and out_valid are stable; in_ready = 0; the new data is not captured; after out_ready the next frame is accepted one cycle later.
- Reset mid-operation: assert rst during pass 1 WAIT. Required:
  - all outputs return to reset values within the same cycle;
  - no out_valid follows for the discarded frame;
  - a fresh frame 2,2,1,1 (in_dir = 0) yields 1,1,2,2.
- DP_LAT = 0 and DP_LAT = 3 builds with frame 3,1,4,2 (in_dir = 0). Required: sorted output 1,2,3,4 at latencies 3 and 12 cycles respectively.
